// File: rtl/left_barrel_shifter_pipe_if.sv
// Stream bus for the pipelined left barrel shifter: the input beat, the shifted result
// and a valid/ready handshake on each side.
interface left_barrel_shifter_pipe_if #(
  parameter int WIDTH  = 8,
  parameter int CTRL_W = 3
);
  logic [WIDTH-1:0]  in;
  logic [CTRL_W-1:0] ctrl;
  logic              rot;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  out;
  logic              lost;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in, ctrl, rot, in_valid, out_ready,
    input  in_ready, out, lost, out_valid
  );

  modport slave (
    input  in, ctrl, rot, in_valid, out_ready,
    output in_ready, out, lost, out_valid
  );
endinterface

// File: rtl/left_barrel_shifter_pipe.sv
// Pipelined shift-left / rotate-left. There is one register stage per ctrl bit, with the
// largest shift first. The whole pipe stalls together on a single advance enable.
module left_barrel_shifter_stage #(
  parameter int WIDTH = 8,
  parameter int K     = 1
) (
  input  logic [WIDTH-1:0] dat,
  input  logic             lost,
  input  logic             rot,
  input  logic             sh,
  output logic [WIDTH-1:0] res,
  output logic             lost_res
);
  logic [WIDTH-1:0] shl;
  logic [WIDTH-1:0] spill;

  // spill holds the top K bits moved down to the bottom: they are the wrap-in for a
  // rotate and the lost bits for a logical shift.
  assign shl   = dat << K;
  assign spill = dat >> (WIDTH - K);

  always_comb begin
    res      = dat;
    lost_res = lost;
    if (sh) begin
      if (rot) begin
        res = shl | spill;
      end else begin
        res      = shl;
        lost_res = lost | (|spill);
      end
    end
  end
endmodule

module left_barrel_shifter_pipe #(
  parameter int WIDTH  = 8,
  parameter int CTRL_W = 3
) (
  input logic                      clk,
  input logic                      rst,
  left_barrel_shifter_pipe_if.slave bus
);
  localparam int STAGES = CTRL_W;
  localparam int NFWD   = (STAGES > 1) ? STAGES - 1 : 1;

  logic                         adv;
  logic [STAGES:0]              vld_pipe;
  logic [STAGES-1:0]            vld_q;
  logic [STAGES-1:0][WIDTH-1:0] dat_q;
  logic [STAGES-1:0]            lost_q;
  // The last stage needs no ctrl/rot register; only its data, lost and valid leave the block.
  logic [NFWD-1:0][CTRL_W-1:0]  ctl_q;
  logic [NFWD-1:0]              rot_q;

  assign vld_pipe     = {vld_q, bus.in_valid};
  assign adv          = !vld_pipe[STAGES] || bus.out_ready;
  assign bus.in_ready = adv;

  assign bus.out       = dat_q[STAGES-1];
  assign bus.lost      = lost_q[STAGES-1];
  assign bus.out_valid = vld_q[STAGES-1];

  for (genvar s = 0; s < STAGES; s++) begin : g_st
    localparam int                B   = STAGES - 1 - s;
    localparam logic [CTRL_W-1:0] SEL = CTRL_W'(1) << B;

    logic [WIDTH-1:0]  dat;
    logic [WIDTH-1:0]  dat_nx;
    logic [CTRL_W-1:0] ctl;
    logic              rot;
    logic              lost;
    logic              lost_nx;
    logic              sh;

    if (s == 0) begin : g_src
      assign dat  = bus.in;
      assign ctl  = bus.ctrl;
      assign rot  = bus.rot;
      assign lost = 1'b0;
    end else begin : g_src
      assign dat  = dat_q[s-1];
      assign ctl  = ctl_q[s-1];
      assign rot  = rot_q[s-1];
      assign lost = lost_q[s-1];
    end

    assign sh = |(ctl & SEL);

    left_barrel_shifter_stage #(
      .WIDTH (WIDTH),
      .K     (1 << B)
    ) u_stage (
      .dat      (dat),
      .lost     (lost),
      .rot      (rot),
      .sh       (sh),
      .res      (dat_nx),
      .lost_res (lost_nx)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q[s]  <= 1'b0;
        dat_q[s]  <= '0;
        lost_q[s] <= 1'b0;
      end else if (adv) begin
        vld_q[s]  <= vld_pipe[s];
        dat_q[s]  <= dat_nx;
        lost_q[s] <= lost_nx;
      end
    end

    if (s < STAGES - 1) begin : g_fwd
      always_ff @(posedge clk) begin
        if (rst) begin
          ctl_q[s] <= '0;
          rot_q[s] <= 1'b0;
        end else if (adv) begin
          ctl_q[s] <= ctl;
          rot_q[s] <= rot;
        end
      end
    end
  end
endmodule
